// File: rtl/cfi_shadow_stack_unit.sv
// Multi-port CFI log engine: buffers call/return commit events in a multi-push queue
// and drains one per cycle into a shadow stack that checks return targets.
module cfi_shadow_stack_unit #(
    parameter int unsigned NR_PORTS    = 2,
    parameter int unsigned XLEN        = 64,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned SS_DEPTH    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NR_PORTS-1:0]               log_valid_i,
    input  logic [2*NR_PORTS-1:0]             log_kind_i,
    input  logic [XLEN*NR_PORTS-1:0]          log_retaddr_i,
    input  logic [XLEN*NR_PORTS-1:0]          log_target_i,
    input  logic                              enable_i,
    input  logic                              enforce_i,
    input  logic                              flush_i,
    input  logic                              fault_ack_i,
    output logic                              halt_o,
    output logic                              fault_valid_o,
    output logic [1:0]                        fault_cause_o,
    output logic [XLEN-1:0]                   fault_tval_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]  queue_usage_o,
    output logic [$clog2(SS_DEPTH+1)-1:0]     ss_depth_o
);

    localparam int unsigned UW  = $clog2(QUEUE_DEPTH+1);
    localparam int unsigned QPW = $clog2(QUEUE_DEPTH);
    localparam int unsigned SW  = $clog2(SS_DEPTH+1);
    localparam int unsigned SPW = $clog2(SS_DEPTH);

    localparam logic [1:0] CAUSE_MISMATCH  = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW  = 2'b10;
    localparam logic [1:0] CAUSE_UNDERFLOW = 2'b11;

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    state_t              r_state, w_state_nxt;

    logic                r_q_ret  [QUEUE_DEPTH];
    logic [XLEN-1:0]     r_q_addr [QUEUE_DEPTH];
    logic [QPW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [UW-1:0]       r_usage;

    logic [XLEN-1:0]     r_ss [SS_DEPTH];
    logic [SW-1:0]       r_sp;

    logic                r_fault_valid, w_fv_nxt;
    logic [1:0]          r_fault_cause, w_cause_nxt;
    logic [XLEN-1:0]     r_fault_tval, w_tval_nxt;

    logic [NR_PORTS-1:0] w_is_ev;
    logic [QPW-1:0]      w_slot [NR_PORTS];
    logic [UW-1:0]       w_n;
    logic [UW-1:0]       w_free;
    logic                w_halt;
    logic                w_push;
    logic                w_pop;
    logic                w_head_ret;
    logic [XLEN-1:0]     w_head_addr;
    logic [SPW-1:0]      w_top_idx;
    logic                w_ss_push;
    logic                w_ss_pop;
    logic                w_fault;
    logic [1:0]          w_fault_cause;
    logic [XLEN-1:0]     w_fault_tval;

    // Each event's slot is offset by the number of events on lower-numbered ports.
    always_comb begin
        w_n = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            w_is_ev[p] = log_valid_i[p] & log_kind_i[2*p+1];
            w_slot[p]  = r_wr_ptr + QPW'(w_n);
            if (w_is_ev[p]) begin
                w_n = w_n + UW'(1);
            end
        end
    end

    assign w_free      = UW'(QUEUE_DEPTH) - r_usage;
    assign w_halt      = enable_i & ((w_n > w_free) | (r_state == ST_HOLD));
    assign w_push      = enable_i & ~w_halt & ~flush_i;
    assign w_pop       = enable_i & ~flush_i & (r_state == ST_RUN) & (r_usage != '0);
    assign w_head_ret  = r_q_ret[r_rd_ptr];
    assign w_head_addr = r_q_addr[r_rd_ptr];
    assign w_top_idx   = SPW'(r_sp - SW'(1));

    always_comb begin
        w_fault       = 1'b0;
        w_fault_cause = '0;
        w_fault_tval  = '0;
        w_ss_push     = 1'b0;
        w_ss_pop      = 1'b0;
        if (w_pop) begin
            if (!w_head_ret) begin
                if (r_sp == SW'(SS_DEPTH)) begin
                    w_fault       = 1'b1;
                    w_fault_cause = CAUSE_OVERFLOW;
                    w_fault_tval  = w_head_addr;
                end else begin
                    w_ss_push = 1'b1;
                end
            end else if (r_sp == '0) begin
                w_fault       = 1'b1;
                w_fault_cause = CAUSE_UNDERFLOW;
                w_fault_tval  = w_head_addr;
            end else begin
                w_ss_pop = 1'b1;
                if (r_ss[w_top_idx] != w_head_addr) begin
                    w_fault       = 1'b1;
                    w_fault_cause = CAUSE_MISMATCH;
                    w_fault_tval  = w_head_addr;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fv_nxt    = r_fault_valid;
        w_cause_nxt = r_fault_cause;
        w_tval_nxt  = r_fault_tval;
        if (flush_i) begin
            w_state_nxt = ST_RUN;
            w_fv_nxt    = 1'b0;
            w_cause_nxt = '0;
            w_tval_nxt  = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (fault_ack_i) begin
                        w_state_nxt = ST_RUN;
                        w_fv_nxt    = 1'b0;
                    end
                end
                default: begin
                    // Monitor mode: valid drops next cycle unless another fault lands.
                    w_fv_nxt = w_fault;
                    if (w_fault) begin
                        w_cause_nxt = w_fault_cause;
                        w_tval_nxt  = w_fault_tval;
                        if (enforce_i) begin
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_RUN;
            r_fault_valid <= 1'b0;
            r_fault_cause <= '0;
            r_fault_tval  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fault_valid <= w_fv_nxt;
            r_fault_cause <= w_cause_nxt;
            r_fault_tval  <= w_tval_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
            r_sp     <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
            r_sp     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + QPW'(w_n);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + QPW'(1);
            end
            r_usage <= r_usage + (w_push ? w_n : '0) - UW'(w_pop);
            if (w_ss_push) begin
                r_sp <= r_sp + SW'(1);
            end else if (w_ss_pop) begin
                r_sp <= r_sp - SW'(1);
            end
        end
    end

    // Storage arrays carry no reset; pointers and counts define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                if (w_is_ev[p]) begin
                    r_q_ret[w_slot[p]]  <= log_kind_i[2*p];
                    r_q_addr[w_slot[p]] <= log_kind_i[2*p] ? log_target_i[p*XLEN +: XLEN]
                                                           : log_retaddr_i[p*XLEN +: XLEN];
                end
            end
        end
        if (w_ss_push) begin
            r_ss[SPW'(r_sp)] <= w_head_addr;
        end
    end

    assign halt_o        = w_halt;
    assign fault_valid_o = r_fault_valid;
    assign fault_cause_o = r_fault_cause;
    assign fault_tval_o  = r_fault_tval;
    assign queue_usage_o = r_usage;
    assign ss_depth_o    = r_sp;

endmodule

// File: tb/tb_cfi_shadow_stack_unit.sv
// Directed bench for cfi_shadow_stack_unit; expected faults are queued as
// stimulus is driven and compared when fault_valid_o rises.
module tb_cfi_shadow_stack_unit;

    localparam int unsigned NP = 2;
    localparam int unsigned XL = 64;

    logic               clk;
    logic               rst_n;
    logic [NP-1:0]      log_valid;
    logic [2*NP-1:0]    log_kind;
    logic [XL*NP-1:0]   log_retaddr;
    logic [XL*NP-1:0]   log_target;
    logic               enable, enforce, flush, fault_ack;
    logic               halt, fault_valid;
    logic [1:0]         fault_cause;
    logic [XL-1:0]      fault_tval;
    logic [3:0]         queue_usage;
    logic [4:0]         ss_depth;

    typedef struct packed {
        logic [1:0]    cause;
        logic [XL-1:0] tval;
    } fault_t;

    fault_t          sb[$];
    logic [XL-1:0]   stack_model[$];
    int              tests = 0;
    int              fails = 0;
    logic            prev_fv = 1'b0;

    cfi_shadow_stack_unit #(
        .NR_PORTS(NP), .XLEN(XL), .QUEUE_DEPTH(8), .SS_DEPTH(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .log_valid_i(log_valid), .log_kind_i(log_kind),
        .log_retaddr_i(log_retaddr), .log_target_i(log_target),
        .enable_i(enable), .enforce_i(enforce), .flush_i(flush), .fault_ack_i(fault_ack),
        .halt_o(halt), .fault_valid_o(fault_valid), .fault_cause_o(fault_cause),
        .fault_tval_o(fault_tval), .queue_usage_o(queue_usage), .ss_depth_o(ss_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then score any newly raised fault against the queue.
    task automatic tick();
        fault_t e;
        @(posedge clk);
        #1;
        if (rst_n && fault_valid && !prev_fv) begin
            check("fault_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("fault_cause", 64'(fault_cause), 64'(e.cause));
                check("fault_tval", fault_tval, e.tval);
            end
        end
        prev_fv = fault_valid;
    endtask

    task automatic idle();
        log_valid   = '0;
        log_kind    = '0;
        log_retaddr = '0;
        log_target  = '0;
    endtask

    task automatic set_log(input int p, input logic [1:0] kind, input logic [XL-1:0] addr);
        log_valid[p]             = 1'b1;
        log_kind[2*p +: 2]       = kind;
        log_retaddr[p*XL +: XL]  = addr;
        log_target[p*XL +: XL]   = addr;
    endtask

    initial begin
        logic [XL-1:0] a;
        rst_n = 1'b0; enable = 1'b1; enforce = 1'b1; flush = 1'b0; fault_ack = 1'b0;
        idle();
        tick(); tick();
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_fv", 64'(fault_valid), 64'd0);
        check("rst_cause", 64'(fault_cause), 64'd0);
        check("rst_tval", fault_tval, 64'd0);
        check("rst_usage", 64'(queue_usage), 64'd0);
        check("rst_depth", 64'(ss_depth), 64'd0);
        rst_n = 1'b1;

        // 1: matching call/return on different ports
        set_log(0, 2'b10, 64'h8000_0104); #1;
        check("t1_halt_a", 64'(halt), 64'd0);
        tick(); idle();
        set_log(1, 2'b11, 64'h8000_0104); #1;
        check("t1_halt_b", 64'(halt), 64'd0);
        tick(); idle();
        check("t1_depth1", 64'(ss_depth), 64'd1);
        tick();
        check("t1_depth0", 64'(ss_depth), 64'd0);
        check("t1_usage", 64'(queue_usage), 64'd0);
        check("t1_fv", 64'(fault_valid), 64'd0);

        // 2: mismatch in enforce mode holds until acknowledged
        enforce = 1'b1;
        set_log(0, 2'b10, 64'h100); tick(); idle();
        set_log(0, 2'b11, 64'h200); sb.push_back('{2'b01, 64'h200}); tick(); idle();
        tick();
        check("t2_fv", 64'(fault_valid), 64'd1);
        check("t2_halt", 64'(halt), 64'd1);
        check("t2_depth", 64'(ss_depth), 64'd0);
        set_log(0, 2'b10, 64'h300); #1;
        check("t2_halt_call", 64'(halt), 64'd1);
        tick(); idle();
        check("t2_no_push", 64'(queue_usage), 64'd0);
        tick();
        check("t2_fv_held", 64'(fault_valid), 64'd1);
        fault_ack = 1'b1; tick(); fault_ack = 1'b0;
        check("t2_fv_ack", 64'(fault_valid), 64'd0);
        check("t2_halt_ack", 64'(halt), 64'd0);

        // 3: mismatch in monitor mode pulses once, draining continues
        enforce = 1'b0;
        set_log(0, 2'b10, 64'h100); tick(); idle();
        set_log(0, 2'b11, 64'h200); sb.push_back('{2'b01, 64'h200}); tick(); idle();
        set_log(0, 2'b10, 64'h500); tick(); idle();
        check("t3_fv", 64'(fault_valid), 64'd1);
        check("t3_halt", 64'(halt), 64'd0);
        check("t3_usage", 64'(queue_usage), 64'd1);
        tick();
        check("t3_fv_pulse", 64'(fault_valid), 64'd0);
        check("t3_depth", 64'(ss_depth), 64'd1);
        check("t3_drained", 64'(queue_usage), 64'd0);
        set_log(0, 2'b11, 64'h500); tick(); idle(); tick();
        check("t3_depth0", 64'(ss_depth), 64'd0);

        // 4: overflow on the 17th call, LIFO unwind, then underflow
        for (int i = 0; i < 17; i++) begin
            a = 64'h10 + 64'(i);
            set_log(0, 2'b10, a);
            if (i == 16) sb.push_back('{2'b10, a});
            tick(); idle();
        end
        tick();
        check("t4_depth_full", 64'(ss_depth), 64'd16);
        for (int i = 15; i >= 0; i--) begin
            set_log(0, 2'b11, 64'h10 + 64'(i)); tick(); idle();
        end
        tick();
        check("t4_depth_empty", 64'(ss_depth), 64'd0);
        set_log(1, 2'b11, 64'h999); sb.push_back('{2'b11, 64'h999}); tick(); idle();
        tick();
        check("t4_depth_after_uf", 64'(ss_depth), 64'd0);

        // 5: queue-full stall, dual push with wrap, port order preserved
        for (int c = 0; c < 6; c++) begin
            set_log(0, 2'b10, 64'h1000 + 64'(8*c));
            set_log(1, 2'b10, 64'h1004 + 64'(8*c));
            tick(); idle();
            stack_model.push_back(64'h1000 + 64'(8*c));
            stack_model.push_back(64'h1004 + 64'(8*c));
        end
        check("t5_usage7", 64'(queue_usage), 64'd7);
        set_log(0, 2'b10, 64'h2000); set_log(1, 2'b10, 64'h2004); #1;
        check("t5_halt", 64'(halt), 64'd1);
        tick();
        check("t5_no_push", 64'(queue_usage), 64'd6);
        check("t5_halt_clear", 64'(halt), 64'd0);
        tick(); idle();
        stack_model.push_back(64'h2000);
        stack_model.push_back(64'h2004);
        check("t5_usage_after", 64'(queue_usage), 64'd7);
        for (int k = 0; k < 7; k++) tick();
        check("t5_usage_drained", 64'(queue_usage), 64'd0);
        check("t5_depth14", 64'(ss_depth), 64'd14);
        while (stack_model.size() > 0) begin
            set_log(0, 2'b11, stack_model.pop_back()); tick(); idle();
        end
        tick();
        check("t5_unwound", 64'(ss_depth), 64'd0);

        // 6: flush with queue 5 / stack 3 drops concurrent log
        for (int c = 0; c < 4; c++) begin
            set_log(0, 2'b10, 64'h3000 + 64'(8*c));
            set_log(1, 2'b10, 64'h3004 + 64'(8*c));
            tick(); idle();
        end
        check("t6_usage5", 64'(queue_usage), 64'd5);
        check("t6_depth3", 64'(ss_depth), 64'd3);
        flush = 1'b1; set_log(0, 2'b10, 64'h4000); tick(); flush = 1'b0; idle();
        check("t6_usage", 64'(queue_usage), 64'd0);
        check("t6_depth", 64'(ss_depth), 64'd0);
        check("t6_fv", 64'(fault_valid), 64'd0);
        tick();
        check("t6_dropped", 64'(queue_usage), 64'd0);

        // flush releases an enforce-mode hold
        enforce = 1'b1;
        set_log(0, 2'b11, 64'hBAD); sb.push_back('{2'b11, 64'hBAD}); tick(); idle();
        tick();
        check("hold_halt", 64'(halt), 64'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_fv", 64'(fault_valid), 64'd0);
        check("flush_halt", 64'(halt), 64'd0);

        // enable=0 ignores logs
        enable = 1'b0;
        set_log(0, 2'b10, 64'h5000); #1;
        check("dis_halt", 64'(halt), 64'd0);
        tick(); idle();
        check("dis_usage", 64'(queue_usage), 64'd0);
        enable = 1'b1;

        // asynchronous reset mid-operation
        set_log(0, 2'b10, 64'h6000); set_log(1, 2'b10, 64'h6004); tick(); tick(); idle();
        check("pre_rst_usage", 64'(queue_usage), 64'd3);
        #2 rst_n = 1'b0; #1;
        check("async_rst_usage", 64'(queue_usage), 64'd0);
        check("async_rst_depth", 64'(ss_depth), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
